bitperm_unit: RTL and testbench

//  Parametrised, pipelined bit-permutation unit; generalises fixed 16-bit reversal.

---
 rtl/bitperm_pkg.sv | 19 +
 rtl/bitperm_if.sv | 38 +++
 rtl/bitperm_core.sv | 42 ++++
 rtl/bitperm_unit.sv | 94 +++++++++
 tb/tb_bitperm_unit.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bitperm_pkg.sv
// Shared types and datapath defaults for the bit-permutation unit.
// The optional out_parity output is enabled by defining BITPERM_PARITY_EN.
package bitperm_pkg;

  typedef enum logic [1:0] {
    PERM_PASS  = 2'd0,
    PERM_REV   = 2'd1,
    PERM_GREV  = 2'd2,
    PERM_GSWAP = 2'd3
  } perm_mode_t;

  localparam int unsigned DP_WIDTH = 16;
  localparam int unsigned DP_GROUP = 8;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/bitperm_if.sv
// Operand/result handshake bundle for bitperm_unit, plus the pipeline squash.
// out_parity exists only when BITPERM_PARITY_EN is defined.
interface bitperm_if #(
  parameter int unsigned WIDTH = bitperm_pkg::DP_WIDTH
);
  import bitperm_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  perm_mode_t       in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef BITPERM_PARITY_EN
  logic             out_parity;

  modport master (
    output flush, in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_parity
  );
  modport slave (
    input  flush, in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_parity
  );
`else
  modport master (
    output flush, in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  flush, in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif

endinterface

// File: rtl/bitperm_core.sv
// Combinational permute(mode, data): pass, full reverse, intra-group reverse,
// group-order reverse. All selects are fixed wiring built by generate loops.
module bitperm_core
  import bitperm_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH,
  parameter int unsigned GROUP = DP_GROUP
) (
  input  perm_mode_t       mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned NGROUPS = WIDTH / GROUP;

  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] grev;
  logic [WIDTH-1:0] gswap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign rev[i] = data[WIDTH-1-i];
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    for (genvar j = 0; j < GROUP; j++) begin : g_bit
      assign grev[g*GROUP+j]  = data[g*GROUP+GROUP-1-j];
      assign gswap[g*GROUP+j] = data[(NGROUPS-1-g)*GROUP+j];
    end
  end

  always_comb begin
    result = data;
    case (mode)
      PERM_PASS:  result = data;
      PERM_REV:   result = rev;
      PERM_GREV:  result = grev;
      PERM_GSWAP: result = gswap;
      default:    result = data;
    endcase
  end

endmodule

// File: rtl/bitperm_unit.sv
// Two-stage valid/ready bit-permutation pipeline (S1 operand, S2 result).
// Defining BITPERM_PARITY_EN adds a registered XOR-reduce of the result.
module bitperm_unit
  import bitperm_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH,
  parameter int unsigned GROUP = DP_GROUP
) (
  input logic      clk,
  input logic      rst,
  bitperm_if.slave bus
);

  if ((GROUP < 1) || (GROUP > WIDTH) || !is_pow2(GROUP) || ((WIDTH % GROUP) != 0))
  begin : g_bad_cfg
    $error("bitperm_unit: illegal WIDTH=%0d GROUP=%0d", WIDTH, GROUP);
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and its payload until that edge; ready may depend
  // combinationally on the downstream ready (in_ready follows out_ready).
  logic             s1_valid;
  logic             s2_valid;
  perm_mode_t       s1_mode;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] perm_data;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_ready;
  logic             accept;
`ifdef BITPERM_PARITY_EN
  logic             s2_parity;
`endif

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  bitperm_core #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_core (
    .mode   (s1_mode),
    .data   (s1_data),
    .result (perm_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv)   s2_valid <= s1_valid;
      if (in_ready) s1_valid <= bus.in_valid;
    end
  end

  // Payload registers only move on their stage's transfer, so a stalled
  // result stays put even if flush or new operands arrive around it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mode <= PERM_PASS;
      s1_data <= '0;
      s2_data <= '0;
`ifdef BITPERM_PARITY_EN
      s2_parity <= 1'b0;
`endif
    end else begin
      if (accept) begin
        s1_mode <= bus.in_mode;
        s1_data <= bus.in_data;
      end
      if (s1_adv && !bus.flush) begin
        s2_data <= perm_data;
`ifdef BITPERM_PARITY_EN
        s2_parity <= ^perm_data;
`endif
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
`ifdef BITPERM_PARITY_EN
  assign bus.out_parity = s2_parity;
`endif

endmodule

// File: tb/tb_bitperm_unit.sv
// Directed bench for bitperm_unit: 16/8 instance with vector table and
// stall/flush/reset sequences, plus a 32/4 instance for the wide-group cases.
module tb_bitperm_unit;
  import bitperm_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst;

  bitperm_if #(.WIDTH(16)) bus ();
  bitperm_if #(.WIDTH(32)) bus32 ();

  bitperm_unit #(.WIDTH(16), .GROUP(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bitperm_unit #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] din;
    logic [15:0] dout;
  } vec_t;

  vec_t           vecs[8];
  int             tests = 0;
  int             fails = 0;
  int             out_cnt = 0;
  int             base;
  int             lat;
  bit             got;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   cur_exp;
  logic [W-1:0]   e;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [1:0] m, input logic [15:0] d,
                       input logic [15:0] x);
    @(posedge clk); #1;
    bus.in_valid = v;
    bus.in_mode  = perm_mode_t'(m);
    bus.in_data  = d;
    cur_exp      = x;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'd0, 16'h0000, 16'h0000);
  endtask

  task automatic run32(input string name, input logic [1:0] m, input logic [31:0] d,
                       input logic [31:0] x);
    @(posedge clk); #1;
    bus32.in_valid = 1'b1;
    bus32.in_mode  = perm_mode_t'(m);
    bus32.in_data  = d;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus32.out_valid) got = 1'b1;
    end
    check({name, "_valid"}, 32'(got), 32'd1);
    check(name, bus32.out_data, x);
`ifdef BITPERM_PARITY_EN
    check({name, "_parity"}, 32'(bus32.out_parity), 32'(^x));
`endif
  endtask

  // scoreboard: expected results queued at accept, popped at each output transfer
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_spurious: got out_data %h, expected no output", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(bus.out_data), 32'(e));
`ifdef BITPERM_PARITY_EN
          check("sb_parity", 32'(bus.out_parity), 32'(^e));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    vecs[0] = '{2'd2, 16'h0180, 16'h8001};
    vecs[1] = '{2'd3, 16'h1234, 16'h3412};
    vecs[2] = '{2'd0, 16'hBEEF, 16'hBEEF};
    vecs[3] = '{2'd1, 16'h0001, 16'h8000};
    vecs[4] = '{2'd1, 16'h00F0, 16'h0F00};
    vecs[5] = '{2'd2, 16'h1234, 16'h482C};
    vecs[6] = '{2'd1, 16'h1234, 16'h2C48};
    vecs[7] = '{2'd3, 16'hA5C3, 16'hC3A5};

    rst = 1'b1;
    bus.flush = 1'b0;  bus.in_valid = 1'b0;  bus.in_mode = PERM_PASS;
    bus.in_data = '0;  bus.out_ready = 1'b1; cur_exp = '0;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.in_mode = PERM_PASS;
    bus32.in_data = '0; bus32.out_ready = 1'b1;

    // reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef BITPERM_PARITY_EN
    check("rst_out_parity", 32'(bus.out_parity), 32'd0);
`endif
    #11 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // two-cycle latency, mode 1
    drive(1'b1, 2'd1, 16'h0001, 16'h8000);
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      if (bus.out_valid) lat = c;
    end
    check("latency", 32'(lat), 32'd2);
    check("lat_data", 32'(bus.out_data), 32'h8000);
`ifdef BITPERM_PARITY_EN
    check("lat_parity", 32'(bus.out_parity), 32'd1);
`endif

    // back-to-back table vectors
    idle(3);
    base = out_cnt;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, vecs[k].mode, vecs[k].din, vecs[k].dout);
      @(negedge clk);
      check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    end
    idle(1);
    @(posedge clk);
    @(negedge clk); #1;
    check("b2b_count", 32'(out_cnt - base), 32'd8);
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: two accepted, third held off, output stable
    idle(2);
    base = out_cnt;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd3, 16'h1234, 16'h3412);
    drive(1'b1, 2'd2, 16'h0180, 16'h8001);
    drive(1'b1, 2'd0, 16'hBEEF, 16'hBEEF);
    @(negedge clk);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall_out_data", 32'(bus.out_data), 32'h3412);
    @(posedge clk); #1;
    check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    check("hold_out_data", 32'(bus.out_data), 32'h3412);
    @(negedge clk);
    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("stall_drain_count", 32'(out_cnt - base), 32'd3);
    check("stall_q_empty", 32'(exp_q.size()), 32'd0);

    // flush with two in flight
    idle(2);
    base = out_cnt;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd1, 16'h0001, 16'h8000);
    drive(1'b1, 2'd3, 16'hA5C3, 16'hC3A5);
    drive(1'b1, 2'd0, 16'h1111, 16'h1111);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("flush_no_emit", 32'(out_cnt - base), 32'd0);

    // flush on an empty pipe drops the simultaneous accept
    drive(1'b1, 2'd0, 16'h5555, 16'h5555);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("flush_drop_accept", 32'(out_cnt - base), 32'd0);

    // asynchronous reset while stalled
    idle(1);
    base = out_cnt;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd1, 16'h1234, 16'h2C48);
    drive(1'b1, 2'd2, 16'h1234, 16'h482C);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("prerst_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_out_data", 32'(bus.out_data), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef BITPERM_PARITY_EN
    check("arst_out_parity", 32'(bus.out_parity), 32'd0);
`endif
    #10 rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("arst_no_spurious", 32'(out_cnt - base), 32'd0);
    check("arst_out_valid_after", 32'(bus.out_valid), 32'd0);

    // WIDTH=32, GROUP=4
    run32("w32_grev_1", 2'd2, 32'h0000_0001, 32'h0000_0008);
    run32("w32_gswap", 2'd3, 32'h1234_5678, 32'h8765_4321);
    run32("w32_rev", 2'd1, 32'h0000_0001, 32'h8000_0000);
    run32("w32_grev_mix", 2'd2, 32'h1234_5678, 32'h84C2_A6E1);
    run32("w32_pass", 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
